// File: rtl/chat_log_display.sv
// chat_log_display: two-user scrolling chat log, stored as a ring of text rows and drawn as 8x16 glyphs
// Ports: clock_65mhz/reset_n clock and async active-low reset; hcount/vcount/display pixel scan;
//        clear drops the whole log; msg_valid/msg_ready/msg_char/msg_user/msg_last character beats;
//        font_addr/font_data external glyph ROM (1-cycle read); pixels RGB out; msg_count committed rows
module chat_log_display #(
   parameter int NROWS = 12,
   parameter int NCHAR = 16,
   parameter int X_USER0 = 150,
   parameter int X_USER1 = 550,
   parameter int Y0 = 25,
   parameter int ROW_PITCH = 50,
   parameter logic [2:0] COLOR0 = 3'b111,
   parameter logic [2:0] COLOR1 = 3'b011
) (
   input  logic clock_65mhz,
   input  logic reset_n,
   input  logic [10:0] hcount,
   input  logic [9:0] vcount,
   input  logic display,
   input  logic clear,
   input  logic msg_valid,
   output logic msg_ready,
   input  logic [7:0] msg_char,
   input  logic msg_user,
   input  logic msg_last,
   output logic [10:0] font_addr,
   input  logic [7:0] font_data,
   output logic [2:0] pixels,
   output logic [$clog2(NROWS+1)-1:0] msg_count
);
   localparam int CW = $clog2(NROWS + 1);
   localparam int HW = $clog2(NROWS);
   localparam int IW = $clog2(NCHAR + 1);
   localparam int XW = $clog2(NCHAR);
   typedef enum logic [1:0] {IDLE, FILL, PAD} state_t;
   state_t state, nstate;
   logic [HW-1:0] head;
   logic [CW-1:0] count;
   logic [IW-1:0] idx;
   logic rdy, cur_user, accept, we, commit, ucur;
   logic [7:0] mem [NROWS][NCHAR];
   logic user_mem [NROWS];
   int ry, slot, dx;
   logic hit, su;
   logic [3:0] gy;
   logic [7:0] ch;
   logic unused;
   logic [6:0] ch1;
   logic [3:0] gy1;
   logic [2:0] bx1, bx2, bx3, clr1, clr2, clr3;
   logic on1, on2, on3;

   assign msg_ready = rdy & ~clear;
   assign msg_count = count;
   assign unused = ch[7];

   // A last beat that fills (or overflows) the row commits at once; otherwise PAD finishes the row.
   always_comb begin
      accept = msg_valid & msg_ready;
      we = accept ? int'(idx) < NCHAR : state == PAD && !clear;
      commit = accept ? msg_last && int'(idx) >= NCHAR - 1 : state == PAD && !clear && int'(idx) == NCHAR - 1;
      ucur = state == IDLE ? msg_user : cur_user;
      nstate = clear || commit ? IDLE : accept ? (msg_last ? PAD : FILL) : state;
   end

   always_ff @(posedge clock_65mhz or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         rdy <= 1'b0;
         head <= '0;
         count <= '0;
         idx <= '0;
         cur_user <= 1'b0;
      end else begin
         state <= nstate;
         rdy <= nstate != PAD;
         if (accept && state == IDLE) cur_user <= msg_user;
         if (clear) begin
            head <= '0;
            count <= '0;
            idx <= '0;
         end else if (commit) begin
            head <= int'(head) == NROWS - 1 ? '0 : head + 1'b1;
            count <= int'(count) == NROWS ? count : count + 1'b1;
            idx <= '0;
         end else if (we) idx <= idx + 1'b1;
      end

   always_ff @(posedge clock_65mhz) begin
      if (we) mem[head][XW'(idx)] <= state == PAD ? 8'h20 : msg_char;
      if (commit) user_mem[head] <= ucur;
   end

   // Find the screen row under vcount, map it to its ring slot, then the column under hcount.
   always_comb begin
      hit = 1'b0;
      ry = 0;
      gy = '0;
      for (int r = 0; r < NROWS; r++)
         if (int'(vcount) >= Y0 + r * ROW_PITCH && int'(vcount) < Y0 + r * ROW_PITCH + 16) begin
            hit = 1'b1;
            ry = r;
            gy = 4'(int'(vcount) - Y0 - r * ROW_PITCH);
         end
      slot = int'(head) + NROWS - int'(count) + ry;
      slot = slot >= NROWS ? slot - NROWS : slot;
      slot = slot >= NROWS ? slot - NROWS : slot;
      su = user_mem[HW'(slot)];
      dx = int'(hcount) - (su ? X_USER1 : X_USER0);
      hit = hit && ry < int'(count) && dx >= 0 && dx < 8 * NCHAR;
      ch = mem[HW'(slot)][XW'(hit ? dx >>> 3 : 0)];
   end

   always_ff @(posedge clock_65mhz or negedge reset_n)
      if (!reset_n) begin
         ch1 <= '0;
         gy1 <= '0;
         bx1 <= '0;
         bx2 <= '0;
         bx3 <= '0;
         clr1 <= '0;
         clr2 <= '0;
         clr3 <= '0;
         on1 <= 1'b0;
         on2 <= 1'b0;
         on3 <= 1'b0;
         font_addr <= '0;
         pixels <= '0;
      end else begin
         ch1 <= ch[6:0];
         gy1 <= gy;
         bx1 <= 3'(dx);
         clr1 <= su ? COLOR1 : COLOR0;
         on1 <= hit & display;
         font_addr <= {ch1, gy1};
         bx2 <= bx1;
         clr2 <= clr1;
         on2 <= on1;
         bx3 <= bx2;
         clr3 <= clr2;
         on3 <= on2;
         pixels <= on3 && font_data[3'd7 - bx3] ? clr3 : 3'b000;
      end
endmodule
